uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_chan_buf.sv | 51 +++++
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit arbiter.
//               Holds the frame FSM state encoding, the channel tag bit
//               values, the grant encoding and the byte-tagging helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // MSB of every transmitted byte identifies the source channel
  localparam logic TAG_DATA = 1'b0;
  localparam logic TAG_PROT = 1'b1;

  // One-hot owner of the frame in flight
  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_DATA = 2'b01;
  localparam logic [1:0] GRANT_PROT = 2'b10;

  function automatic logic [7:0] tag_byte(input logic tag, input logic [6:0] payload);
    return {tag, payload};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_chan_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_chan_buf
// Description : One-entry byte buffer for one arbiter input channel.
//               Captures the 7-bit payload on valid && ready; ready is the
//               inverse of the registered full flag, so a captured byte is
//               visible to the arbiter in the following cycle.
// Ports       : i_clk, i_reset_n      - clock, async active-low reset
//               i_valid, i_dat        - offered byte (bit 7 is not stored)
//               o_ready               - buffer empty, byte accepted this cycle
//               i_clear               - arbiter took the byte
//               o_full, o_dat         - buffer status and stored payload
// Revision    : 1.0 - initial release
// ============================================================================
module uart_chan_buf (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_dat,
  output logic       o_ready,
  input  logic       i_clear,
  output logic       o_full,
  output logic [6:0] o_dat
);

  logic       r_full;
  logic [6:0] r_dat;
  logic       w_unused_msb;

  // The tag replaces bit 7 downstream, so the incoming bit 7 is dropped
  assign w_unused_msb = i_dat[7];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_full <= 1'b0;
      r_dat  <= '0;
    end else if (i_clear) begin
      // Clear only happens while full, so it never collides with a capture
      r_full <= 1'b0;
    end else if (i_valid && !r_full) begin
      r_full <= 1'b1;
      r_dat  <= i_dat[6:0];
    end
  end

  assign o_ready = ~r_full;
  assign o_full  = r_full;
  assign o_dat   = r_dat;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Merges a data channel and a protocol channel onto a single
//               UART transmitter. Data has fixed priority; a starve counter
//               lets a pending protocol byte through after STARVE_LIMIT
//               consecutive data grants. Each byte is tagged in bit 7.
// Ports       : i_clk, i_reset_n            - clock, async active-low reset
//               i_data_valid/i_data_dat     - data channel in, o_data_ready
//               i_prot_valid/i_prot_dat     - protocol channel in, o_prot_ready
//               o_tx_dat, o_tx_start        - tagged byte and start pulse
//               i_tx_ready                  - transmitter idle
//               o_busy, o_grant             - frame in progress, frame owner
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_data_valid,
  input  logic [7:0] i_data_dat,
  output logic       o_data_ready,
  input  logic       i_prot_valid,
  input  logic [7:0] i_prot_dat,
  output logic       o_prot_ready,
  output logic [7:0] o_tx_dat,
  output logic       o_tx_start,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic [1:0] o_grant
);

  // A zero limit still needs a 1-bit counter; it simply never saturates above 0
  localparam int                 c_cnt_w      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

  state_t             r_state;
  logic               r_tx_start;
  logic [7:0]         r_tx_dat;
  logic [1:0]         r_grant;
  logic               r_wait_cnt;
  logic [c_cnt_w-1:0] r_starve_cnt;

  logic       w_data_full;
  logic       w_prot_full;
  logic [6:0] w_data_buf;
  logic [6:0] w_prot_buf;
  logic       w_fire;
  logic       w_starved;
  logic       w_win_prot;
  logic       w_clr_data;
  logic       w_clr_prot;

  uart_chan_buf u_data_buf (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_data_valid),
    .i_dat     (i_data_dat),
    .o_ready   (o_data_ready),
    .i_clear   (w_clr_data),
    .o_full    (w_data_full),
    .o_dat     (w_data_buf)
  );

  uart_chan_buf u_prot_buf (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_prot_valid),
    .i_dat     (i_prot_dat),
    .o_ready   (o_prot_ready),
    .i_clear   (w_clr_prot),
    .o_full    (w_prot_full),
    .o_dat     (w_prot_buf)
  );

  // A grant is made only from IDLE with the transmitter idle and work pending
  assign w_fire     = (r_state == ST_IDLE) && i_tx_ready && (w_data_full || w_prot_full);
  assign w_starved  = (STARVE_LIMIT != 0) && (r_starve_cnt == c_starve_max);
  assign w_win_prot = w_prot_full && (!w_data_full || w_starved);
  assign w_clr_data = w_fire && !w_win_prot;
  assign w_clr_prot = w_fire &&  w_win_prot;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_tx_start   <= 1'b0;
      r_tx_dat     <= 8'h00;
      r_grant      <= GRANT_NONE;
      r_wait_cnt   <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      // Starvation only counts while a protocol byte is actually waiting
      if (!w_prot_full) begin
        r_starve_cnt <= '0;
      end else if (w_fire) begin
        if (w_win_prot) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_state    <= ST_START;
            r_tx_start <= 1'b1;
            if (w_win_prot) begin
              r_tx_dat <= tag_byte(TAG_PROT, w_prot_buf);
              r_grant  <= GRANT_PROT;
            end else begin
              r_tx_dat <= tag_byte(TAG_DATA, w_data_buf);
              r_grant  <= GRANT_DATA;
            end
          end
        end
        ST_START: begin
          r_tx_start <= 1'b0;
          r_wait_cnt <= 1'b0;
          r_state    <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          // Bounded so a transmitter that never shows busy cannot hang us
          if (!i_tx_ready || r_wait_cnt) begin
            r_state <= ST_WAIT_DONE;
          end else begin
            r_wait_cnt <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (i_tx_ready) begin
            r_state <= ST_IDLE;
            r_grant <= GRANT_NONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx_dat   = r_tx_dat;
  assign o_tx_start = r_tx_start;
  assign o_grant    = r_grant;
  assign o_busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter. Inputs are
//               driven 1 time unit after the rising edge; outputs are read at
//               the same point. A falling-edge monitor logs every start pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic       i_data_valid;
  logic [7:0] i_data_dat;
  logic       o_data_ready;
  logic       i_prot_valid;
  logic [7:0] i_prot_dat;
  logic       o_prot_ready;
  logic [7:0] o_tx_dat;
  logic       o_tx_start;
  logic       i_tx_ready;
  logic       o_busy;
  logic [1:0] o_grant;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] q_dat[$];
  logic [1:0] q_grant[$];
  int         q_cyc[$];
  int         q_cnt[$];

  uart_tx_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_data_valid (i_data_valid),
    .i_data_dat   (i_data_dat),
    .o_data_ready (o_data_ready),
    .i_prot_valid (i_prot_valid),
    .i_prot_dat   (i_prot_dat),
    .o_prot_ready (o_prot_ready),
    .o_tx_dat     (o_tx_dat),
    .o_tx_start   (o_tx_start),
    .i_tx_ready   (i_tx_ready),
    .o_busy       (o_busy),
    .o_grant      (o_grant)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    cyc = cyc + 1;
    if (o_tx_start) begin
      q_dat.push_back(o_tx_dat);
      q_grant.push_back(o_grant);
      q_cyc.push_back(cyc);
      q_cnt.push_back(int'(dut.r_starve_cnt));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    q_dat.delete();
    q_grant.delete();
    q_cyc.delete();
    q_cnt.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_tx_start"},   32'(o_tx_start),   32'd0);
    chk({pfx, "_tx_dat"},     32'(o_tx_dat),     32'h00);
    chk({pfx, "_grant"},      32'(o_grant),      32'd0);
    chk({pfx, "_busy"},       32'(o_busy),       32'd0);
    chk({pfx, "_data_ready"}, 32'(o_data_ready), 32'd1);
    chk({pfx, "_prot_ready"}, 32'(o_prot_ready), 32'd1);
  endtask

  logic [1:0] exp_g [6];
  int         exp_c [6];

  initial begin
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    exp_c = '{1, 2, 3, 4, 0, 0};

    i_reset_n    = 1'b0;
    i_data_valid = 1'b0;
    i_data_dat   = 8'h00;
    i_prot_valid = 1'b0;
    i_prot_dat   = 8'h00;
    i_tx_ready   = 1'b1;
    tick(3);

    // Reset state
    chk_reset_outputs("rst");
    i_reset_n = 1'b1;
    tick(2);

    // Single data byte C1: start two cycles after acceptance, tag cleared
    clear_log();
    i_data_valid = 1'b1;
    i_data_dat   = 8'hC1;
    chk("s1_ready_accept", 32'(o_data_ready), 32'd1);
    tick(1);
    i_data_valid = 1'b0;
    chk("s1_ready_full", 32'(o_data_ready), 32'd0);
    chk("s1_no_start_yet", 32'(o_tx_start), 32'd0);
    tick(1);
    chk("s1_start", 32'(o_tx_start), 32'd1);
    chk("s1_tx_dat", 32'(o_tx_dat), 32'h41);
    chk("s1_grant", 32'(o_grant), 32'h1);
    chk("s1_ready_again", 32'(o_data_ready), 32'd1);
    chk("s1_busy", 32'(o_busy), 32'd1);
    tick(1);
    chk("s1_start_one_cycle", 32'(o_tx_start), 32'd0);
    tick(2);
    chk("s1_wait_done_busy", 32'(o_busy), 32'd1);
    chk("s1_wait_done_grant", 32'(o_grant), 32'h1);
    tick(1);
    chk("s1_idle_busy", 32'(o_busy), 32'd0);
    chk("s1_idle_grant", 32'(o_grant), 32'h0);
    chk("s1_dat_held", 32'(o_tx_dat), 32'h41);

    // Data 12 and prot 35 in the same cycle: data first, then prot
    tick(2);
    clear_log();
    i_data_valid = 1'b1;
    i_data_dat   = 8'h12;
    i_prot_valid = 1'b1;
    i_prot_dat   = 8'h35;
    tick(1);
    i_data_valid = 1'b0;
    i_prot_valid = 1'b0;
    tick(20);
    chk("s2_frames", 32'(q_dat.size()), 32'd2);
    if (q_dat.size() >= 2) begin
      chk("s2_dat0", 32'(q_dat[0]), 32'h12);
      chk("s2_grant0", 32'(q_grant[0]), 32'h1);
      chk("s2_dat1", 32'(q_dat[1]), 32'hB5);
      chk("s2_grant1", 32'(q_grant[1]), 32'h2);
      chk("s2_gap_ge4", 32'((q_cyc[1] - q_cyc[0]) >= 4), 32'd1);
    end

    // Continuous data with prot pending: four data frames, one prot, data again
    clear_log();
    i_data_valid = 1'b1;
    i_data_dat   = 8'h05;
    i_prot_valid = 1'b1;
    i_prot_dat   = 8'h7F;
    tick(1);
    i_prot_valid = 1'b0;
    tick(32);
    i_data_valid = 1'b0;
    tick(20);
    chk("s3_enough_frames", 32'(q_dat.size() >= 6), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (k < q_dat.size()) begin
        chk($sformatf("s3_grant%0d", k), 32'(q_grant[k]), 32'(exp_g[k]));
        chk($sformatf("s3_cnt%0d", k), 32'(q_cnt[k]), 32'(exp_c[k]));
        chk($sformatf("s3_dat%0d", k), 32'(q_dat[k]), (k == 4) ? 32'hFF : 32'h05);
      end
    end

    // Transmitter held busy in IDLE: no grant until ready rises
    tick(5);
    chk("s4_idle_before", 32'(o_busy), 32'd0);
    clear_log();
    i_tx_ready   = 1'b0;
    i_data_valid = 1'b1;
    i_data_dat   = 8'h22;
    i_prot_valid = 1'b1;
    i_prot_dat   = 8'h33;
    tick(1);
    i_data_valid = 1'b0;
    i_prot_valid = 1'b0;
    tick(49);
    chk("s4_no_starts", 32'(q_dat.size()), 32'd0);
    chk("s4_data_ready", 32'(o_data_ready), 32'd0);
    chk("s4_prot_ready", 32'(o_prot_ready), 32'd0);
    chk("s4_busy", 32'(o_busy), 32'd0);
    i_tx_ready = 1'b1;
    tick(1);
    chk("s4_start", 32'(o_tx_start), 32'd1);
    chk("s4_grant", 32'(o_grant), 32'h1);
    chk("s4_dat", 32'(o_tx_dat), 32'h22);
    tick(10);
    chk("s4_frames", 32'(q_dat.size()), 32'd2);
    if (q_dat.size() >= 2) begin
      chk("s4_prot_dat", 32'(q_dat[1]), 32'hB3);
      chk("s4_prot_grant", 32'(q_grant[1]), 32'h2);
    end

    // Reset during WAIT_DONE with both buffers full
    tick(5);
    clear_log();
    i_data_valid = 1'b1;
    i_data_dat   = 8'h0A;
    i_prot_valid = 1'b1;
    i_prot_dat   = 8'h0B;
    tick(1);
    i_data_valid = 1'b0;
    i_prot_valid = 1'b0;
    tick(1);
    i_data_valid = 1'b1;
    i_data_dat   = 8'h0C;
    chk("s5_refill_ready", 32'(o_data_ready), 32'd1);
    tick(1);
    i_data_valid = 1'b0;
    i_tx_ready   = 1'b0;
    tick(1);
    chk("s5_busy", 32'(o_busy), 32'd1);
    chk("s5_data_full", 32'(o_data_ready), 32'd0);
    chk("s5_prot_full", 32'(o_prot_ready), 32'd0);
    chk("s5_grant", 32'(o_grant), 32'h1);
    tick(3);
    chk("s5_still_busy", 32'(o_busy), 32'd1);
    i_reset_n = 1'b0;
    #1;
    chk_reset_outputs("s5_async");
    tick(2);
    i_reset_n  = 1'b1;
    i_tx_ready = 1'b1;
    tick(20);
    chk("s5_no_new_start", 32'(q_dat.size()), 32'd1);
    chk_reset_outputs("s5_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
